// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and parity helper.
// Also intended for the future receive block.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Parity bit that makes the data bits plus parity sum to even (odd = 0) or odd (odd = 1).
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// The counter is held at zero while clear is high, so the first period starts at a known phase.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-line UART transmitter: 8-bit LSB-first frames with optional parity and 1 or 2
// stop bits. All status outputs are registered; tx_dv is only sampled in IDLE.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_dv,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  output logic                      tx_serial,
  output logic                      tx_busy,
  output logic                      tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  uart_tx_state_t            state;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      parity_bit;
  logic [2:0]                bit_idx;
  logic [2:0]                next_idx;
  logic                      stop_cnt;
  logic                      timer_clear;
  logic                      bit_tick;

  // Holding the timer in IDLE makes the start bit exactly one bit period after acceptance.
  assign timer_clear = (state == IDLE);
  assign next_idx    = bit_idx + 3'd1;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  // tx_serial is loaded with the next bit on the same edge the state advances, so the
  // line level always matches the state being held for the following bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      parity_bit <= 1'b0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (tx_dv) begin
            shift      <= tx_byte;
            parity_bit <= uart_parity(tx_byte, PAR_ODD);
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            tx_busy    <= 1'b1;
            tx_serial  <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            bit_idx   <= '0;
            tx_serial <= shift[0];
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              if (PAR_EN) begin
                tx_serial <= parity_bit;
                state     <= PARITY;
              end else begin
                tx_serial <= 1'b1;
                state     <= STOP;
              end
            end else begin
              bit_idx   <= next_idx;
              tx_serial <= shift[next_idx];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx_serial <= 1'b1;
            state     <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= 1'b0;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: four instances (plain, even parity, odd parity,
// two stop bits) at CLKS_PER_BIT=4, hand-written expected line patterns checked by a monitor.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  typedef struct {
    logic [11:0] bits;   // bit 0 = start bit, transmitted first
    int          nbits;
    bit          abort;  // frame is expected to be cut short by reset
    bit          b2b;    // frame must start exactly one cycle after the previous tx_done
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dv;
  logic [7:0] tb_byte [4];
  logic [3:0] ser, busy, done;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint ncyc  = 0;

  frame_t exp_q [4][$];
  frame_t cur   [4];
  bit     in_fr [4];
  int     cyc_i [4];
  int     errs  [4];
  longint done_at [4];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst(rst_n), .tx_dv(dv[0]), .tx_byte(tb_byte[0]),
    .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst_n), .tx_dv(dv[1]), .tx_byte(tb_byte[1]),
    .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst_n), .tx_dv(dv[2]), .tx_byte(tb_byte[2]),
    .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst_n), .tx_dv(dv[3]), .tx_byte(tb_byte[3]),
    .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  function automatic frame_t mk(logic [11:0] bits, int nbits, bit abort, bit b2b);
    frame_t f;
    f.bits  = bits;
    f.nbits = nbits;
    f.abort = abort;
    f.b2b   = b2b;
    return f;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name, int k);
    n_cmp++;
    n_bad++;
    $display("FAIL %s[%0d] (t=%0t)", name, k, $time);
  endtask

  // Monitor step for instance k, run once per falling edge.
  task automatic mon_step(int k);
    int   f;
    logic e;
    if (rst_n !== 1'b1) begin
      if (in_fr[k]) begin
        if (!cur[k].abort) fail_now("frame_killed_by_reset", k);
        else chk("line_before_reset", k, errs[k], 0);
      end
      in_fr[k] = 1'b0;
      return;
    end
    if (!in_fr[k]) begin
      if (busy[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          fail_now("unexpected_frame", k);
          cur[k] = mk(12'hFFF, 10, 1'b0, 1'b0);
        end else begin
          cur[k] = exp_q[k].pop_front();
        end
        if (cur[k].b2b) chk("gap_after_done", k, 32'(ncyc - done_at[k]), 1);
        in_fr[k] = 1'b1;
        cyc_i[k] = 0;
        errs[k]  = 0;
      end else if (done[k] !== 1'b0) begin
        fail_now("spurious_done", k);
      end
    end
    if (in_fr[k]) begin
      f = cur[k].nbits * CPB;
      if (cyc_i[k] < f) begin
        e = cur[k].bits[cyc_i[k] / CPB];
        if (ser[k] !== e || busy[k] !== 1'b1 || done[k] !== 1'b0) errs[k]++;
        if (cyc_i[k] == f - 1) chk("line_and_busy_errors", k, errs[k], 0);
      end else begin
        chk("done_busy_line", k, {29'd0, done[k], busy[k], ser[k]}, 32'b101);
        if (cur[k].abort) fail_now("completed_despite_reset", k);
        done_at[k] = ncyc;
        in_fr[k]   = 1'b0;
      end
      cyc_i[k]++;
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    for (int k = 0; k < 4; k++) mon_step(k);
  end

  task automatic send(int k, logic [7:0] b);
    @(negedge clk);
    dv[k]      = 1'b1;
    tb_byte[k] = b;
    @(negedge clk);
    dv[k]      = 1'b0;
  endtask

  task automatic wait_idle(int k, int budget);
    int n = 0;
    while ((exp_q[k].size() != 0 || in_fr[k]) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("frame_within_budget", k, (n < budget) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(int k, logic lvl, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[k] !== lvl && n < budget);
    chk("busy_level_wait", k, busy[k], lvl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [4];
    seq = '{8'h01, 8'h02, 8'h04, 8'h08};
    rst_n = 1'b0;
    dv    = '0;
    for (int k = 0; k < 4; k++) begin
      tb_byte[k] = 8'h00;
      in_fr[k]   = 1'b0;
      done_at[k] = 0;
    end

    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("reset_serial", k, ser[k], 1);
      chk("reset_busy", k, busy[k], 0);
      chk("reset_done", k, done[k], 0);
    end
    rst_n = 1'b1;

    // Reset mid-frame while sending 0xA5, then a clean 0x3C frame
    exp_q[0].push_back(mk(12'b00_1_10100101_0, 10, 1'b1, 1'b0));
    send(0, 8'hA5);
    repeat (10) @(negedge clk);
    chk("busy_before_reset", 0, busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_serial", 0, ser[0], 1);
    chk("async_reset_busy", 0, busy[0], 0);
    chk("async_reset_done", 0, done[0], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("aborted_frame_consumed", 0, exp_q[0].size(), 0);
    exp_q[0].push_back(mk(12'b00_1_00111100_0, 10, 1'b0, 1'b0));
    send(0, 8'h3C);
    wait_idle(0, 100);

    // 0x55, no parity, one stop bit
    exp_q[0].push_back(mk(12'b00_1_01010101_0, 10, 1'b0, 1'b0));
    send(0, 8'h55);
    wait_idle(0, 100);

    // 0x80 with even and odd parity
    exp_q[1].push_back(mk(12'b0_1_1_10000000_0, 11, 1'b0, 1'b0));
    send(1, 8'h80);
    wait_idle(1, 100);
    exp_q[2].push_back(mk(12'b0_1_0_10000000_0, 11, 1'b0, 1'b0));
    send(2, 8'h80);
    wait_idle(2, 100);

    // 0xFF with two stop bits
    exp_q[3].push_back(mk(12'b0_11_11111111_0, 11, 1'b0, 1'b0));
    send(3, 8'hFF);
    wait_idle(3, 100);

    // 0x22 with ignored 0x11 pulses at E0+10 and E0+39, then 0x33 in the tx_done cycle
    exp_q[0].push_back(mk(12'b00_1_00100010_0, 10, 1'b0, 1'b0));
    @(negedge clk);
    dv[0] = 1'b1;
    tb_byte[0] = 8'h22;
    for (int m = 1; m <= 42; m++) begin
      @(negedge clk);
      case (m)
        1, 11, 40, 42: dv[0] = 1'b0;
        10, 39: begin dv[0] = 1'b1; tb_byte[0] = 8'h11; end
        41: begin
          exp_q[0].push_back(mk(12'b00_1_00110011_0, 10, 1'b0, 1'b1));
          dv[0] = 1'b1;
          tb_byte[0] = 8'h33;
        end
        default: ;
      endcase
    end
    wait_idle(0, 150);

    // Four back-to-back frames from a held tx_dv
    exp_q[0].push_back(mk(12'b00_1_00000001_0, 10, 1'b0, 1'b0));
    exp_q[0].push_back(mk(12'b00_1_00000010_0, 10, 1'b0, 1'b1));
    exp_q[0].push_back(mk(12'b00_1_00000100_0, 10, 1'b0, 1'b1));
    exp_q[0].push_back(mk(12'b00_1_00001000_0, 10, 1'b0, 1'b1));
    @(negedge clk);
    dv[0] = 1'b1;
    tb_byte[0] = seq[0];
    for (int i = 0; i < 4; i++) begin
      wait_busy(0, 1'b1, 10);
      if (i < 3) begin
        tb_byte[0] = seq[i+1];
        wait_busy(0, 1'b0, 60);
      end else begin
        dv[0] = 1'b0;
      end
    end
    wait_idle(0, 250);

    repeat (5) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("leftover_expected_frames", k, exp_q[k].size(), 0);
      chk("line_idle_at_end", k, {31'd0, ser[k]}, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
